reg_cmd_master: RTL and testbench
=================================

# reg_cmd_master

Upstream requester for the register-control slave. Accepts write/read commands on a valid/ready interface, buffers them in a small command FIFO, and drives them onto the single-cycle register bus (`addr`/`sel`/`wr`/`wdata`, returning `ready`/`rdata`). It obeys the slave's one-cycle read turnaround, captures read data, and returns each read result on a valid/ready response port.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, register address width.
- `DATA_WIDTH`, 16, register data width.
- `FIFO_DEPTH`, 4, command FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  register address.
- `cmd_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `addr`  out  ADDR_WIDTH  bus address to slave.
- `sel`  out  1  bus select.
- `wr`  out  1  bus write strobe.
- `wdata`  out  DATA_WIDTH  bus write data.
- `ready`  in  1  slave ready.
- `rdata`  in  DATA_WIDTH  slave read data, valid one cycle after a read is issued.
- `rsp_valid`  out  1  read response held.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_addr`  out  ADDR_WIDTH  address of the returned read.
- `rsp_rdata`  out  DATA_WIDTH  returned read data.

## Operation
- Command FIFO: push on `cmd_valid & cmd_ready`; `cmd_ready = !full`. When full, no push even if a pop happens in the same cycle. Pointers wrap modulo `FIFO_DEPTH`; an occupancy counter (width log2(FIFO_DEPTH)+1) drives full/empty.
- FSM states: IDLE, BUS, RD_WAIT.
  - IDLE: `sel=0`, `wr=0`. Go to BUS when the FIFO is non-empty and either the head is a write or `rsp_valid=0`.
  - BUS: `sel=1`; `addr`/`wr`/`wdata` come from the FIFO head.
    - Write with `ready=1`: write completes and the FIFO pops. Stay in BUS if the next entry is eligible, else go to IDLE.
    - Read with `ready=1`: read is issued, the FIFO pops, latch `addr`, go to RD_WAIT.
    - `ready=0`: hold all bus outputs, no pop.
  - RD_WAIT: `sel=1`, `wr=0`, `addr` = latched read address. `sel` must stay high here because the slave only re-asserts `ready` while selected.
    - Capture `rdata` into `rsp_rdata` and the latched address into `rsp_addr`; set `rsp_valid`.
    - Next state: BUS if the next entry is eligible, else IDLE.
- Read eligibility: a read head is never issued while `rsp_valid=1`; `sel` drops to 0 (IDLE) until the response is taken. Writes are never blocked by `rsp_valid`.
- Response register: `rsp_valid` clears on `rsp_valid & rsp_ready`. A capture in the same cycle as a take is impossible by construction, because a read cannot issue while `rsp_valid=1`.
- Unused bus outputs (`addr`, `wdata`) are 0 in IDLE.

## Timing
- Reset values: `cmd_ready=1`, `sel=0`, `wr=0`, `addr=0`, `wdata=0`, `rsp_valid=0`, `rsp_addr=0`, `rsp_rdata=0`. FIFO empty, FSM in IDLE.
- A command pushed in cycle C appears on the bus in C+1 at the earliest.
- Write: completes in C+1 when `ready=1`.
- Read: issued C+1, `rdata` sampled at end of C+2, `rsp_valid=1` from C+3.
- Throughput: back-to-back writes 1 per cycle. A read occupies 2 bus cycles (BUS + RD_WAIT); the next command may issue in the cycle after RD_WAIT.
- Reset asserted in any state, including RD_WAIT: all state returns to reset values on the next edge. Queued commands and any pending response are discarded. No bus strobe is asserted in the cycle following reset.

## Test plan
- Reset: hold `rst` 3 cycles with `cmd_valid=1` -> `cmd_ready=1`, `sel=0`, `rsp_valid=0`, no push occurs.
- Write burst: push writes to addr 0x10..0x13 with data 0xA000..0xA003 in consecutive cycles, slave `ready=1` -> 4 consecutive cycles with `sel=1`, `wr=1` and matching addr/data; FIFO empties.
- Read after write: write 0xBEEF to 0x20, then read 0x20 -> `sel` stays high through RD_WAIT; `rsp_valid=1` with `rsp_addr=0x20`, `rsp_rdata=0xBEEF` exactly 3 cycles after the read push.
- Response backpressure: push read 0x01, read 0x02, write 0x03 with `rsp_ready=0` -> first response held; second read is not issued (`sel=0`); after `rsp_ready` pulses, read 0x02 issues, then the write.
- FIFO full: hold `ready=0` and push 5 commands -> `cmd_ready=0` after 4 are accepted; the 5th is held until the first pop.
- Reset mid-read: assert `rst` during RD_WAIT -> next cycle `sel=0`, `rsp_valid=0`, FIFO empty; a subsequent read returns normally.

Source files
------------

// File: rtl/reg_cmd_master.sv
// reg_cmd_master
// Upstream requester for the register-control slave. Write/read commands
// arrive on a valid/ready port, queue in a small FIFO and are driven onto
// the single-cycle register bus. A read holds the bus for one extra cycle
// (RD_WAIT) so the slave's read data can be captured. The result is then
// held on a valid/ready response port.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_wr, cmd_addr, cmd_wdata       command contents (1 = write)
//   addr, sel, wr, wdata              register bus outputs to the slave
//   ready, rdata                      slave ready and read data (one cycle late)
//   rsp_valid/rsp_ready               read response handshake
//   rsp_addr, rsp_rdata               address and data of the returned read

module reg_cmd_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  sel,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RD_WAIT
    } state_t;

    state_t state;
    state_t next_state;

    logic                  fifo_wr    [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      nxt_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    logic [ADDR_WIDTH-1:0] rd_addr;

    logic                  rsp_hold;
    logic                  head_avail;
    logic                  head_is_wr;
    logic                  follow_avail;
    logic                  follow_is_wr;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    // A full FIFO refuses a push even when the head pops in the same cycle.
    assign push      = cmd_valid && !full;
    assign nxt_ptr   = rd_ptr + PTR_W'(1);

    // Look-ahead used to decide the state after this cycle. The entry that
    // will sit at the head next cycle may be one being pushed right now, so
    // the incoming command is considered when the FIFO would otherwise be
    // empty; this gives C+1 issue latency and one write per cycle.
    // rsp_hold is the response still being held next cycle, the only thing
    // that blocks a read from issuing.
    assign rsp_hold     = rsp_valid && !rsp_ready;
    assign head_avail   = !empty || push;
    assign head_is_wr   = empty ? cmd_wr : fifo_wr[rd_ptr];
    assign follow_avail = (count >= CNT_W'(2)) || push;
    assign follow_is_wr = (count >= CNT_W'(2)) ? fifo_wr[nxt_ptr] : cmd_wr;

    // Command storage; contents need no reset because the pointers and
    // occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_wr[wr_ptr]    <= cmd_wr;
            fifo_addr[wr_ptr]  <= cmd_addr;
            fifo_wdata[wr_ptr] <= cmd_wdata;
        end
    end

    // State, FIFO pointers/occupancy, latched read address and the
    // response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_addr   <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= next_state;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= nxt_ptr;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (state == BUS && ready && !fifo_wr[rd_ptr]) begin
                rd_addr <= fifo_addr[rd_ptr];
            end
            // A capture and a take never coincide: no read issues while a
            // response is held.
            if (state == RD_WAIT) begin
                rsp_valid <= 1'b1;
                rsp_addr  <= rd_addr;
                rsp_rdata <= rdata;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Next-state and bus outputs. sel stays high through RD_WAIT because
    // the slave only drives ready while it is selected.
    always_comb begin
        next_state = state;
        sel        = 1'b0;
        wr         = 1'b0;
        addr       = '0;
        wdata      = '0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (head_avail && (head_is_wr || !rsp_hold)) begin
                    next_state = BUS;
                end
            end
            BUS: begin
                sel   = 1'b1;
                wr    = fifo_wr[rd_ptr];
                addr  = fifo_addr[rd_ptr];
                wdata = fifo_wdata[rd_ptr];
                if (ready) begin
                    pop = 1'b1;
                    if (fifo_wr[rd_ptr]) begin
                        if (follow_avail && (follow_is_wr || !rsp_hold)) begin
                            next_state = BUS;
                        end else begin
                            next_state = IDLE;
                        end
                    end else begin
                        next_state = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                sel  = 1'b1;
                addr = rd_addr;
                // The response becomes valid next cycle, so only a write
                // may follow immediately.
                if (head_avail && head_is_wr) begin
                    next_state = BUS;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_cmd_master.sv
// tb_reg_cmd_master
// Directed bench for reg_cmd_master. A small register-slave model answers
// the bus (writes on sel&wr&ready, read data registered one cycle later).
// Inputs change 1 time unit after each rising edge; outputs are checked at
// the same point, after the DUT has settled.

module tb_reg_cmd_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic [7:0]  addr;
    logic        sel;
    logic        wr;
    logic [15:0] wdata;
    logic        ready;
    logic [15:0] rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_addr;
    logic [15:0] rsp_rdata;

    logic [15:0] smem [256];

    int vecCount  = 0;
    int missCount = 0;

    reg_cmd_master #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .addr      (addr),
        .sel       (sel),
        .wr        (wr),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_addr  (rsp_addr),
        .rsp_rdata (rsp_rdata)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register slave model: single-cycle write, read data one cycle later.
    always @(posedge clk) begin
        if (sel && ready) begin
            if (wr) begin
                smem[addr] <= wdata;
            end else begin
                rdata <= smem[addr];
            end
        end
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [7:0] a,
                                 input logic [15:0] d);
        cmd_valid = v;
        cmd_wr    = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic checkBus(input string tag, input logic s, input logic w,
                            input logic [7:0] a, input logic [15:0] d);
        checkOutput({tag, ".sel"}, 32'(sel), 32'(s));
        checkOutput({tag, ".wr"}, 32'(wr), 32'(w));
        checkOutput({tag, ".addr"}, 32'(addr), 32'(a));
        checkOutput({tag, ".wdata"}, 32'(wdata), 32'(d));
    endtask

    task automatic checkRsp(input string tag, input logic v, input logic [7:0] a,
                            input logic [15:0] d);
        checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(v));
        if (v) begin
            checkOutput({tag, ".rsp_addr"}, 32'(rsp_addr), 32'(a));
            checkOutput({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(d));
        end
    endtask

    initial begin
        rst       = 1'b1;
        ready     = 1'b1;
        rsp_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'h55, 16'h1234);

        // Reset held 3 cycles with a command offered: nothing is accepted.
        repeat (3) tick();
        checkOutput("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        checkBus("rst", 1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst.rsp_addr", 32'(rsp_addr), 32'd0);
        checkOutput("rst.rsp_rdata", 32'(rsp_rdata), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        checkBus("post_rst", 1'b0, 1'b0, 8'h00, 16'h0000);

        // Write burst: one bus write per cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 8'h10 + 8'(i), 16'hA000 + 16'(i));
            tick();
            checkBus($sformatf("burst%0d", i), 1'b1, 1'b1, 8'h10 + 8'(i), 16'hA000 + 16'(i));
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        checkBus("burst_end", 1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("burst_end.cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("burst.slave13", 32'(smem[8'h13]), 32'h0000A003);

        // Read after write.
        applyStimulus(1'b1, 1'b1, 8'h20, 16'hBEEF);
        tick();
        checkBus("raw.wr", 1'b1, 1'b1, 8'h20, 16'hBEEF);
        applyStimulus(1'b1, 1'b0, 8'h20, 16'h0000);
        tick();
        checkOutput("raw.rd.sel", 32'(sel), 32'd1);
        checkOutput("raw.rd.wr", 32'(wr), 32'd0);
        checkOutput("raw.rd.addr", 32'(addr), 32'h20);
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        checkBus("raw.wait", 1'b1, 1'b0, 8'h20, 16'h0000);
        checkRsp("raw.wait", 1'b0, 8'h00, 16'h0000);
        tick();
        checkRsp("raw.rsp", 1'b1, 8'h20, 16'hBEEF);
        checkOutput("raw.rsp.sel", 32'(sel), 32'd0);
        tick();
        checkRsp("raw.taken", 1'b0, 8'h00, 16'h0000);

        // Preload slave locations 1 and 2 through the DUT.
        applyStimulus(1'b1, 1'b1, 8'h01, 16'h1111);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h02, 16'h2222);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        checkOutput("preload.sel", 32'(sel), 32'd0);

        // Response backpressure: second read waits until the first is taken.
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h01, 16'h0000);
        tick();
        checkOutput("bp.r1.sel", 32'(sel), 32'd1);
        checkOutput("bp.r1.addr", 32'(addr), 32'h01);
        applyStimulus(1'b1, 1'b0, 8'h02, 16'h0000);
        tick();
        checkBus("bp.r1wait", 1'b1, 1'b0, 8'h01, 16'h0000);
        applyStimulus(1'b1, 1'b1, 8'h03, 16'h3333);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("bp.blocked.sel", 32'(sel), 32'd0);
        checkRsp("bp.rsp1", 1'b1, 8'h01, 16'h1111);
        tick();
        checkOutput("bp.held.sel", 32'(sel), 32'd0);
        checkRsp("bp.held", 1'b1, 8'h01, 16'h1111);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("bp.taken.rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("bp.r2.sel", 32'(sel), 32'd1);
        checkOutput("bp.r2.wr", 32'(wr), 32'd0);
        checkOutput("bp.r2.addr", 32'(addr), 32'h02);
        tick();
        checkBus("bp.r2wait", 1'b1, 1'b0, 8'h02, 16'h0000);
        tick();
        checkBus("bp.w3", 1'b1, 1'b1, 8'h03, 16'h3333);
        checkRsp("bp.rsp2", 1'b1, 8'h02, 16'h2222);
        tick();
        checkOutput("bp.idle.sel", 32'(sel), 32'd0);
        checkOutput("bp.rsp2held", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        tick();
        checkOutput("bp.rsp2taken", 32'(rsp_valid), 32'd0);

        // FIFO full with the slave stalled.
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 8'h40 + 8'(i), 16'hC000 + 16'(i));
            tick();
        end
        applyStimulus(1'b1, 1'b1, 8'h44, 16'hC004);
        checkOutput("full.cmd_ready", 32'(cmd_ready), 32'd0);
        checkBus("full.hold0", 1'b1, 1'b1, 8'h40, 16'hC000);
        tick();
        checkOutput("full.still_full", 32'(cmd_ready), 32'd0);
        checkBus("full.hold1", 1'b1, 1'b1, 8'h40, 16'hC000);
        ready = 1'b1;
        tick();
        checkOutput("full.popped.cmd_ready", 32'(cmd_ready), 32'd1);
        checkBus("full.w41", 1'b1, 1'b1, 8'h41, 16'hC001);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        checkBus("full.w42", 1'b1, 1'b1, 8'h42, 16'hC002);
        tick();
        checkBus("full.w43", 1'b1, 1'b1, 8'h43, 16'hC003);
        tick();
        checkBus("full.w44", 1'b1, 1'b1, 8'h44, 16'hC004);
        tick();
        checkBus("full.drained", 1'b0, 1'b0, 8'h00, 16'h0000);

        // Reset during RD_WAIT discards the queued write and the response.
        applyStimulus(1'b1, 1'b0, 8'h20, 16'h0000);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h50, 16'h5555);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        checkBus("mid.rdwait", 1'b1, 1'b0, 8'h20, 16'h0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkBus("mid.after_rst", 1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("mid.rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid.cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        checkOutput("mid.fifo_empty.sel", 32'(sel), 32'd0);
        checkOutput("mid.rsp_valid2", 32'(rsp_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h13, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("mid.rd.sel", 32'(sel), 32'd1);
        checkOutput("mid.rd.addr", 32'(addr), 32'h13);
        tick();
        checkBus("mid.rd.wait", 1'b1, 1'b0, 8'h13, 16'h0000);
        tick();
        checkRsp("mid.rsp", 1'b1, 8'h13, 16'hA003);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
